// File: rtl/arbiter_burst_scheduler_if.sv
// Handshake bundle between NUM_REQ requesters, the burst scheduler and the
// shared downstream beat channel.
//
// Signals:
//   enable      - allows new grants
//   req_valid   - per-requester beat valid
//   req_last    - per-requester last beat of burst (qualified by req_valid)
//   req_ready   - per-requester beat accepted
//   out_valid   - downstream beat valid
//   out_ready   - downstream accept
//   out_last    - last beat of the current grant
//   grant       - one-hot grant
//   select      - binary index of the granted requester
//   grant_valid - a grant is active
//   beat_count  - beats already transferred in the current grant
//   burst_done  - one-cycle pulse after the final beat of a grant
//
// Modports:
//   slave  - the scheduler side
//   master - the requester/downstream environment side
interface arbiter_burst_scheduler_if #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
);
  localparam int SEL_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  logic               enable;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] req_ready;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic [NUM_REQ-1:0] grant;
  logic [SEL_W-1:0]   select;
  logic               grant_valid;
  logic [CNT_W-1:0]   beat_count;
  logic               burst_done;

  modport slave (
    input  enable, req_valid, req_last, out_ready,
    output req_ready, out_valid, out_last, grant, select,
           grant_valid, beat_count, burst_done
  );

  modport master (
    output enable, req_valid, req_last, out_ready,
    input  req_ready, out_valid, out_last, grant, select,
           grant_valid, beat_count, burst_done
  );
endinterface

// File: rtl/arbiter_burst_scheduler.sv
// Round-robin burst scheduler: shares one downstream beat channel among
// NUM_REQ requesters. A grant is held for a whole burst, ending on the
// requester's last beat or after MAX_BURST beats. Control only; the data mux
// is built outside from select.
//
// Ports:
//   ap_clk   - clock, all state on the rising edge
//   areset_n - asynchronous active-low reset
//   bus      - scheduler side of arbiter_burst_scheduler_if (see interface)
module arbiter_burst_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                       ap_clk,
  input  logic                       areset_n,
  arbiter_burst_scheduler_if.slave   bus
);
  localparam int SEL_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam int SUM_W = SEL_W + 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   select_q, select_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               grant_valid_q, grant_valid_d;
  logic [CNT_W-1:0]   beat_count_q, beat_count_d;
  logic               burst_done_q, burst_done_d;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_sel;
  logic [SUM_W-1:0]   scan_idx;
  logic               out_valid;
  logic               ends_here;
  logic               beat;
  logic               burst_end;

  // Scan requesters starting at rr_ptr and wrapping; first valid one wins.
  // The index is kept one bit wider so the wrap can be done by subtraction.
  always_comb begin
    pick_found = 1'b0;
    pick_sel   = '0;
    scan_idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx = {1'b0, rr_ptr_q} + SUM_W'(off);
      if (scan_idx >= SUM_W'(NUM_REQ)) begin
        scan_idx = scan_idx - SUM_W'(NUM_REQ);
      end
      if (!pick_found && bus.req_valid[scan_idx[SEL_W-1:0]]) begin
        pick_found = 1'b1;
        pick_sel   = scan_idx[SEL_W-1:0];
      end
    end
  end

  // A beat is the last of the grant either because the requester says so or
  // because the cap is reached on this beat.
  assign ends_here = bus.req_last[select_q] | (beat_count_q == CNT_W'(MAX_BURST - 1));
  assign out_valid = grant_valid_q & bus.req_valid[select_q];
  assign beat      = out_valid & bus.out_ready;
  assign burst_end = beat & ends_here;

  // Next-state logic. enable only gates new grants, never an active burst.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    select_d      = select_q;
    rr_ptr_d      = rr_ptr_q;
    grant_valid_d = grant_valid_q;
    beat_count_d  = beat_count_q;
    burst_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable && pick_found) begin
          grant_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_sel;
          select_d      = pick_sel;
          grant_valid_d = 1'b1;
          beat_count_d  = '0;
          state_d       = GRANT;
        end
      end
      GRANT: begin
        if (burst_end) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          beat_count_d  = '0;
          rr_ptr_d      = (select_q == SEL_W'(NUM_REQ - 1)) ? '0 : select_q + 1'b1;
          burst_done_d  = 1'b1;
          state_d       = IDLE;
        end else if (beat) begin
          beat_count_d = beat_count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset clears everything, including a burst in progress.
  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      select_q      <= '0;
      rr_ptr_q      <= '0;
      grant_valid_q <= 1'b0;
      beat_count_q  <= '0;
      burst_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      select_q      <= select_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_valid_q <= grant_valid_d;
      beat_count_q  <= beat_count_d;
      burst_done_q  <= burst_done_d;
    end
  end

  assign bus.out_valid   = out_valid;
  assign bus.out_last    = out_valid & ends_here;
  assign bus.req_ready   = grant_q & {NUM_REQ{bus.out_ready}};
  assign bus.grant       = grant_q;
  assign bus.select      = select_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.beat_count  = beat_count_q;
  assign bus.burst_done  = burst_done_q;
endmodule

// File: tb/tb_arbiter_burst_scheduler.sv
// Self-checking bench for arbiter_burst_scheduler (NUM_REQ=4, MAX_BURST=16).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. Expected beats are queued when stimulus is driven and popped
// by the monitor whenever a beat is presented downstream.
module tb_arbiter_burst_scheduler;
  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 16;
  localparam int SEL_W     = 2;

  logic ap_clk = 1'b0;
  logic areset_n;

  arbiter_burst_scheduler_if #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) bus ();

  arbiter_burst_scheduler #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
    .ap_clk  (ap_clk),
    .areset_n(areset_n),
    .bus     (bus)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic             last;
  } beat_t;

  typedef struct {
    logic [3:0]       req_valid;
    logic [SEL_W-1:0] exp_sel;
  } rr_vec_t;

  beat_t   exp_q[$];
  rr_vec_t vecs[12];

  int       n_checks = 0;
  int       n_fail   = 0;
  int       done_count = 0;
  int       beats;
  bit       seen;
  logic [3:0] drv_v, drv_l, exp_grant;
  logic     drv_en;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst_n_i, input logic en_i, input logic [3:0] valid_i,
                               input logic [3:0] last_i, input logic ready_i);
    @(posedge ap_clk);
    #1;
    areset_n      = rst_n_i;
    bus.enable    = en_i;
    bus.req_valid = valid_i;
    bus.req_last  = last_i;
    bus.out_ready = ready_i;
  endtask

  task automatic pushBeats(input logic [SEL_W-1:0] sel, input logic last, input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{sel: sel, last: last});
    end
  endtask

  // Monitor: invariants every cycle, and scoreboard pop on each presented beat.
  always @(negedge ap_clk) begin
    beat_t b;
    if (areset_n) begin
      checkOutput("grant onehot0", 32'($onehot0(bus.grant)), 32'd1);
      checkOutput("req_ready onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
      if (bus.out_valid) checkOutput("out_valid implies grant_valid", 32'(bus.grant_valid), 32'd1);
      if (bus.burst_done) done_count++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected beat", 32'd1, 32'd0);
        end else begin
          b = exp_q.pop_front();
          checkOutput("beat select", 32'(bus.select), 32'(b.sel));
          checkOutput("beat out_last", 32'(bus.out_last), 32'(b.last));
          checkOutput("beat req_ready", 32'(bus.req_ready[bus.select]), 32'd1);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Arbitration table: rr_ptr starts at 0 and moves to winner+1 after each burst.
    vecs[0]  = '{4'b1111, 2'd0};
    vecs[1]  = '{4'b1111, 2'd1};
    vecs[2]  = '{4'b1111, 2'd2};
    vecs[3]  = '{4'b1111, 2'd3};
    vecs[4]  = '{4'b1111, 2'd0};
    vecs[5]  = '{4'b0001, 2'd0};
    vecs[6]  = '{4'b1000, 2'd3};
    vecs[7]  = '{4'b0110, 2'd1};
    vecs[8]  = '{4'b0110, 2'd2};
    vecs[9]  = '{4'b0011, 2'd0};
    vecs[10] = '{4'b0101, 2'd2};
    vecs[11] = '{4'b0010, 2'd1};

    // Reset held with every requester asking.
    areset_n      = 1'b0;
    bus.enable    = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge ap_clk);
      checkOutput("reset grant", 32'(bus.grant), 32'd0);
      checkOutput("reset grant_valid", 32'(bus.grant_valid), 32'd0);
      checkOutput("reset req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("reset select", 32'(bus.select), 32'd0);
      checkOutput("reset beat_count", 32'(bus.beat_count), 32'd0);
    end

    // Single-beat bursts back to back, one IDLE bubble between grants.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b1, vecs[i].req_valid, 4'b1111, 1'b1);
      pushBeats(vecs[i].exp_sel, 1'b1, 1);
      @(negedge ap_clk);
      if (i == 0) begin
        checkOutput("rr idle before first grant", 32'(bus.grant_valid), 32'd0);
      end else begin
        checkOutput("rr burst_done", 32'(bus.burst_done), 32'd1);
        checkOutput("rr bubble", 32'(bus.grant_valid), 32'd0);
      end
      @(negedge ap_clk);
      exp_grant = 4'b0001 << vecs[i].exp_sel;
      checkOutput("rr grant_valid", 32'(bus.grant_valid), 32'd1);
      checkOutput("rr select", 32'(bus.select), 32'(vecs[i].exp_sel));
      checkOutput("rr grant", 32'(bus.grant), 32'(exp_grant));
      checkOutput("rr beat_count", 32'(bus.beat_count), 32'd0);
      checkOutput("rr out_last", 32'(bus.out_last), 32'd1);
    end
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
    @(negedge ap_clk);
    checkOutput("rr final burst_done", 32'(bus.burst_done), 32'd1);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
    checkOutput("rr burst_done pulses", 32'(done_count), 32'd12);

    // Burst cap: requester 2 never says last, so the grant ends after 16 beats.
    pushBeats(2'd2, 1'b0, 15);
    pushBeats(2'd2, 1'b1, 1);
    pushBeats(2'd2, 1'b0, 1);
    pushBeats(2'd2, 1'b1, 1);
    applyStimulus(1'b1, 1'b1, 4'b0100, 4'b0000, 1'b1);
    @(negedge ap_clk);
    for (int k = 0; k < MAX_BURST; k++) begin
      @(negedge ap_clk);
      checkOutput("cap beat_count", 32'(bus.beat_count), 32'(k));
      checkOutput("cap select", 32'(bus.select), 32'd2);
      checkOutput("cap out_last", 32'(bus.out_last), (k == MAX_BURST - 1) ? 32'd1 : 32'd0);
    end
    @(negedge ap_clk);
    checkOutput("cap burst_done", 32'(bus.burst_done), 32'd1);
    checkOutput("cap bubble", 32'(bus.grant_valid), 32'd0);
    @(negedge ap_clk);
    checkOutput("cap regrant valid", 32'(bus.grant_valid), 32'd1);
    checkOutput("cap regrant select", 32'(bus.select), 32'd2);
    checkOutput("cap regrant beat_count", 32'(bus.beat_count), 32'd0);
    applyStimulus(1'b1, 1'b1, 4'b0100, 4'b0100, 1'b1);
    @(negedge ap_clk);
    checkOutput("cap regrant out_last", 32'(bus.out_last), 32'd1);
    checkOutput("cap regrant beat_count 1", 32'(bus.beat_count), 32'd1);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
    @(negedge ap_clk);
    checkOutput("cap regrant burst_done", 32'(bus.burst_done), 32'd1);

    // Backpressure and a 2-cycle valid gap on a 4-beat burst from requester 1.
    pushBeats(2'd1, 1'b0, 3);
    pushBeats(2'd1, 1'b1, 1);
    beats = 0;
    seen  = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      drv_v = (beats < 4 && c != 4 && c != 5) ? 4'b0010 : 4'b0000;
      drv_l = (beats == 3) ? 4'b0010 : 4'b0000;
      applyStimulus(1'b1, 1'b1, drv_v, drv_l, (c % 2) == 0);
      @(negedge ap_clk);
      if (bus.req_valid[1] && bus.req_ready[1]) beats++;
      if (bus.grant_valid) checkOutput("gap select held", 32'(bus.select), 32'd1);
      if (bus.grant_valid && !bus.req_valid[1]) checkOutput("gap out_valid", 32'(bus.out_valid), 32'd0);
      if (bus.burst_done) seen = 1'b1;
    end
    checkOutput("gap burst finished", 32'(seen), 32'd1);
    checkOutput("gap beat total", 32'(beats), 32'd4);

    // enable drops during beat 2 of a 5-beat burst from requester 2.
    pushBeats(2'd2, 1'b0, 4);
    pushBeats(2'd2, 1'b1, 1);
    beats = 0;
    seen  = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      drv_v  = {1'b1, beats < 5, 2'b00};
      drv_l  = {1'b1, beats == 4, 2'b00};
      drv_en = (beats == 0);
      applyStimulus(1'b1, drv_en, drv_v, drv_l, 1'b1);
      @(negedge ap_clk);
      if (bus.req_valid[2] && bus.req_ready[2]) beats++;
      if (bus.grant_valid) checkOutput("enable select held", 32'(bus.select), 32'd2);
      if (bus.burst_done) seen = 1'b1;
    end
    checkOutput("enable burst finished", 32'(seen), 32'd1);
    checkOutput("enable beat total", 32'(beats), 32'd5);
    pushBeats(2'd3, 1'b1, 1);
    repeat (4) begin
      applyStimulus(1'b1, 1'b0, 4'b1000, 4'b1000, 1'b1);
      @(negedge ap_clk);
      checkOutput("no grant while disabled", 32'(bus.grant_valid), 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 4'b1000, 4'b1000, 1'b1);
    @(negedge ap_clk);
    checkOutput("enable idle cycle", 32'(bus.grant_valid), 32'd0);
    @(negedge ap_clk);
    checkOutput("enable next grant", 32'(bus.grant), 32'b1000);
    checkOutput("enable next select", 32'(bus.select), 32'd3);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
    @(negedge ap_clk);
    checkOutput("enable next burst_done", 32'(bus.burst_done), 32'd1);

    // Reset pulsed on beat 3 of a burst; pointer restarts at 0.
    pushBeats(2'd1, 1'b0, 3);
    applyStimulus(1'b1, 1'b1, 4'b0010, 4'b0000, 1'b1);
    @(negedge ap_clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      checkOutput("midreset beat_count", 32'(bus.beat_count), 32'(k));
    end
    #1 areset_n = 1'b0;
    #1;
    checkOutput("midreset grant", 32'(bus.grant), 32'd0);
    checkOutput("midreset grant_valid", 32'(bus.grant_valid), 32'd0);
    checkOutput("midreset select", 32'(bus.select), 32'd0);
    checkOutput("midreset beat_count 0", 32'(bus.beat_count), 32'd0);
    checkOutput("midreset req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("midreset out_valid", 32'(bus.out_valid), 32'd0);
    pushBeats(2'd3, 1'b1, 1);
    applyStimulus(1'b1, 1'b1, 4'b1000, 4'b1000, 1'b1);
    @(negedge ap_clk);
    checkOutput("postreset idle", 32'(bus.grant_valid), 32'd0);
    @(negedge ap_clk);
    checkOutput("postreset grant", 32'(bus.grant), 32'b1000);
    checkOutput("postreset select", 32'(bus.select), 32'd3);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
    @(negedge ap_clk);
    checkOutput("postreset burst_done", 32'(bus.burst_done), 32'd1);

    @(posedge ap_clk);
    #1;
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
